design_select_sequencer: RTL and testbench
==========================================

# design_select_sequencer

Sequencer that owns the design-select bus in front of the design multiplexer and performs safe, glitch-free switches between the 64 design slots. It accepts a select request through a valid/ready handshake and rejects unpopulated slots. Each accepted switch runs the same sequence: gate outputs, change the select, hold the new design in reset, settle, then release. It sits between the chip-level configuration logic and the `des_sel` / per-design reset inputs of the design instantiation wrapper.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: drain/settle wait, in cycles, before and after the reset pulse; legal range ≥1.
- `RESET_CYCLES`, default 8: cycles the selected design is held in reset; legal range ≥1.
- `POPULATED`, default 64'h0000_0000_007F_FCEE: bit i set means slot i holds a design.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: select request present.
- `req_sel` in 6: requested slot.
- `req_ready` out 1: request can be accepted this cycle.
- `des_sel` out 6: slot select driven to the multiplexer.
- `des_reset` out 1: active-high reset to the selected design.
- `out_en` out 1: the selected design's outputs may reach the pins.
- `busy` out 1: a switch sequence is in progress.
- `done` out 1: one-cycle pulse when a switch completes.
- `err` out 1: one-cycle pulse when a request names an unpopulated slot.

## Operation
- States: IDLE, DRAIN, SWITCH, RESET, RELEASE.
- `req_ready` is 1 only in IDLE.
- A request is accepted when `req_valid & req_ready` is sampled.
- **Populated slot:** the request latches `req_sel` and the FSM moves to DRAIN.
- **Unpopulated slot:** `err` pulses on the next cycle, there is no state change, and `des_sel` is unchanged.
- **DRAIN:** `out_en`=0, `des_sel` still holds the old slot; lasts SETTLE_CYCLES.
- **SWITCH:** `des_sel` takes the latched slot; lasts 1 cycle.
- **RESET:** `des_reset`=1; lasts RESET_CYCLES.
- **RELEASE:** `des_reset`=0, `out_en`=0; lasts SETTLE_CYCLES.
- **Return to IDLE:** `out_en`=1 and `done`=1 for that first IDLE cycle.
- **Same-slot request:** requesting the current slot runs the full sequence. This is the defined way to re-reset a design.
- `busy` = (state ≠ IDLE).
- All wait timing comes from one down-counter. It is loaded with N−1 on state entry, and the FSM advances when the counter reaches 0.
- **Reset values (`reset`=0):** state IDLE, `des_sel`=0, `des_reset`=0, `out_en`=0, `busy`=0, `done`=0, `err`=0, counter 0. `out_en` stays 0 until the first completed switch.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Take acceptance as cycle 0. Then:
  - DRAIN: cycles 1..S.
  - SWITCH: cycle S+1 (`des_sel` changes here).
  - RESET: cycles S+2..S+R+1.
  - RELEASE: cycles S+R+2..2S+R+1.
  - `done` and `out_en` rise at cycle 2S+R+2.
- With defaults (S=2, R=8), latency is 14 cycles.
- `err` latency is 1 cycle. `req_ready` stays 1 on that cycle, so back-to-back requests are legal.
- `req_valid` held during busy: not accepted, no side effects. The request is taken in the first IDLE cycle, which is the same cycle `done` is high.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronously). Any in-flight request is discarded.
- `des_reset` and `out_en` are never both 1.
- `des_sel` changes only while `out_en`=0.

## Structure
- Shared package `design_select_pkg`:
  - state enum `dss_state_t`.
  - `NUM_DESIGNS`=64.
  - `SEL_W`=6.
  - default `POPULATED` mask constant.
- Sub-module `dss_timer`: a loadable down-counter with a `zero` flag, sized from max(SETTLE_CYCLES, RESET_CYCLES).
- Top: FSM, request latch, populated-mask lookup and output registers.

## Test plan
- **Reset:** assert `reset`=0 mid-RESET state → all outputs return to 0 in the same cycle, `des_sel`=0. After release, `req_ready`=1.
- **Normal switch:** defaults; request slot 13 at cycle 0 → `out_en`=0 from cycle 1, `des_sel`=13 at cycle 3, `des_reset`=1 for cycles 4..11, `done`=1 and `out_en`=1 at cycle 14.
- **Unpopulated slot:** request slot 30 → `err`=1 at cycle 1, `busy` stays 0, `des_sel` unchanged.
- **Request while busy:** hold a request for slot 6 while busy with slot 12 → `req_ready`=0 throughout. Slot 6 is accepted on the `done` cycle, with no lost or duplicate `done`.
- **Same-slot re-reset:** request the current slot 2 → full 14-cycle sequence, `des_sel` stays 2, `des_reset` pulses for 8 cycles.
- **Parameter corner:** S=1, R=1 → latency 5 cycles. Invariants checked every cycle: `des_reset` and `out_en` never both 1; `des_sel` changes only while `out_en`=0.

Source files
------------

// File: rtl/design_select_pkg.sv
// Shared types and constants for the design-select sequencer: state encoding,
// bus widths and the default slot-population mask.
package design_select_pkg;

    localparam int NUM_DESIGNS = 64;
    localparam int SEL_W       = 6;

    localparam logic [NUM_DESIGNS-1:0] DEFAULT_POPULATED = 64'h0000_0000_007F_FCEE;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SWITCH,
        RESET,
        RELEASE
    } dss_state_t;

    // Counter width able to hold max_cycles-1, never narrower than one bit.
    function automatic int cnt_width(input int max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/dss_timer.sv
// Loadable down-counter that saturates at zero; the FSM loads N-1 on state
// entry and advances once zero is flagged.
module dss_timer
    import design_select_pkg::*;
#(
    parameter  int MAX_CYCLES = 8,
    localparam int W          = cnt_width(MAX_CYCLES)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/design_select_sequencer.sv
// Owns the design-select bus: accepts a slot request, then gates outputs,
// switches the select, pulses the design reset, settles and releases.
module design_select_sequencer
    import design_select_pkg::*;
#(
    parameter int                     SETTLE_CYCLES = 2,
    parameter int                     RESET_CYCLES  = 8,
    parameter logic [NUM_DESIGNS-1:0] POPULATED     = DEFAULT_POPULATED
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_sel,
    output logic             req_ready,
    output logic [SEL_W-1:0] des_sel,
    output logic             des_reset,
    output logic             out_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int CNT_W      = cnt_width(MAX_CYCLES);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LD  = CNT_W'(RESET_CYCLES - 1);

    dss_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_lat_q, sel_lat_d;
    logic [SEL_W-1:0] des_sel_q, des_sel_d;
    logic             des_reset_q, des_reset_d;
    logic             out_en_q, out_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_zero;

    dss_timer #(
        .MAX_CYCLES(MAX_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .zero    (tmr_zero)
    );

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        sel_lat_d    = sel_lat_q;
        des_sel_d    = des_sel_q;
        des_reset_d  = des_reset_q;
        out_en_d     = out_en_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (POPULATED[req_sel]) begin
                        sel_lat_d    = req_sel;
                        out_en_d     = 1'b0;
                        state_d      = DRAIN;
                        tmr_load     = 1'b1;
                        tmr_load_val = SETTLE_LD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (tmr_zero) begin
                    des_sel_d = sel_lat_q;
                    state_d   = SWITCH;
                end
            end
            SWITCH: begin
                des_reset_d  = 1'b1;
                state_d      = RESET;
                tmr_load     = 1'b1;
                tmr_load_val = RESET_LD;
            end
            RESET: begin
                if (tmr_zero) begin
                    des_reset_d  = 1'b0;
                    state_d      = RELEASE;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_LD;
                end
            end
            RELEASE: begin
                if (tmr_zero) begin
                    out_en_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_lat_q   <= '0;
            des_sel_q   <= '0;
            des_reset_q <= 1'b0;
            out_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_lat_q   <= sel_lat_d;
            des_sel_q   <= des_sel_d;
            des_reset_q <= des_reset_d;
            out_en_q    <= out_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Ready is a pure decode of the state register, so inputs never reach it combinationally.
    assign req_ready = (state_q == IDLE);
    assign des_sel   = des_sel_q;
    assign des_reset = des_reset_q;
    assign out_en    = out_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_design_select_sequencer.sv
// Scoreboard bench: the driver pushes the expected done/err event for each request,
// a negedge monitor pops and compares it and checks the output invariants every cycle.
module tb_design_select_sequencer;
    import design_select_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic             req_valid, req_ready, des_reset, out_en, busy, done, err;
    logic [SEL_W-1:0] req_sel, des_sel;

    logic             c_req_valid, c_req_ready, c_des_reset, c_out_en, c_busy, c_done, c_err;
    logic [SEL_W-1:0] c_req_sel, c_des_sel;

    design_select_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .des_sel  (des_sel),
        .des_reset(des_reset),
        .out_en   (out_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    design_select_sequencer #(
        .SETTLE_CYCLES(1),
        .RESET_CYCLES (1)
    ) dut_c (
        .clock    (clock),
        .reset    (reset),
        .req_valid(c_req_valid),
        .req_sel  (c_req_sel),
        .req_ready(c_req_ready),
        .des_sel  (c_des_sel),
        .des_reset(c_des_reset),
        .out_en   (c_out_en),
        .busy     (c_busy),
        .done     (c_done),
        .err      (c_err)
    );

    typedef struct {
        bit               is_err;
        int               cyc;
        logic [SEL_W-1:0] sel;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic issue(input logic [SEL_W-1:0] sel, input bit is_err, input int ev_cyc,
                         input logic [SEL_W-1:0] ev_sel);
        exp_t e;
        req_valid = 1'b1;
        req_sel   = sel;
        e.is_err  = is_err;
        e.cyc     = ev_cyc;
        e.sel     = ev_sel;
        sb.push_back(e);
    endtask

    // Monitor: scoreboard pop on done/err, plus per-cycle invariants.
    initial begin
        logic [SEL_W-1:0] prev_sel   = '0;
        logic [SEL_W-1:0] c_prev_sel = '0;
        logic             prev_oe    = 1'b0;
        logic             c_prev_oe  = 1'b0;
        int               hi_cnt     = 0;
        exp_t             e;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("excl", int'(des_reset & out_en), 0);
                check("c_excl", int'(c_des_reset & c_out_en), 0);
                if (des_sel !== prev_sel) check("sel_gated", int'(out_en | prev_oe), 0);
                if (c_des_sel !== c_prev_sel) check("c_sel_gated", int'(c_out_en | c_prev_oe), 0);
                if (done || err) begin
                    if (sb.size() == 0) begin
                        check("unexpected_event", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("ev_kind_err", int'(err), int'(e.is_err));
                        check("ev_kind_done", int'(done), int'(!e.is_err));
                        check("ev_cycle", cyc, e.cyc);
                        check("ev_des_sel", int'(des_sel), int'(e.sel));
                    end
                end
                if (des_reset) begin
                    hi_cnt++;
                end else if (hi_cnt != 0) begin
                    check("reset_len", hi_cnt, 8);
                    hi_cnt = 0;
                end
            end else begin
                hi_cnt = 0;
            end
            prev_sel   = des_sel;
            prev_oe    = out_en;
            c_prev_sel = c_des_sel;
            c_prev_oe  = c_out_en;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int hi;
        req_valid   = 1'b0;
        req_sel     = '0;
        c_req_valid = 1'b0;
        c_req_sel   = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_des_sel", int'(des_sel), 0);
        check("rst_out_en", int'(out_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_flags", int'({des_reset, done, err}), 0);
        reset = 1'b1;
        @(negedge clock);
        check("rdy_after_rst", int'(req_ready), 1);

        // Normal switch to slot 13: 14-cycle latency
        t0 = cyc;
        issue(6'd13, 1'b0, t0 + 14, 6'd13);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            check("n_des_reset", int'(des_reset), int'(k >= 4 && k <= 11));
            check("n_out_en", int'(out_en), int'(k == 14));
            check("n_des_sel", int'(des_sel), (k >= 3) ? 13 : 0);
            check("n_busy", int'(busy), int'(k != 14));
        end

        // Unpopulated slots 30 then 4, back to back
        t0 = cyc;
        issue(6'd30, 1'b1, t0 + 1, 6'd13);
        @(negedge clock);
        issue(6'd4, 1'b1, t0 + 2, 6'd13);
        check("u_busy", int'(busy), 0);
        check("u_ready", int'(req_ready), 1);
        @(negedge clock);
        req_valid = 1'b0;
        check("u_busy2", int'(busy), 0);
        check("u_des_sel", int'(des_sel), 13);
        check("u_out_en", int'(out_en), 1);
        @(negedge clock);

        // Request for slot 6 held while busy with slot 12
        t0 = cyc;
        issue(6'd12, 1'b0, t0 + 14, 6'd12);
        @(negedge clock);
        issue(6'd6, 1'b0, t0 + 28, 6'd6);
        check("h_ready", int'(req_ready), 0);
        for (int k = 2; k <= 14; k++) begin
            @(negedge clock);
            check("h_ready", int'(req_ready), int'(k == 14));
        end
        @(negedge clock);
        req_valid = 1'b0;
        check("h_busy_again", int'(busy), 1);
        for (int k = 16; k <= 28; k++) begin
            @(negedge clock);
            if (k == 16) check("h_sel_old", int'(des_sel), 12);
            if (k == 17) check("h_sel_new", int'(des_sel), 6);
        end

        // Switch to slot 2, then re-request slot 2
        t0 = cyc;
        issue(6'd2, 1'b0, t0 + 14, 6'd2);
        repeat (14) @(negedge clock);
        t0 = cyc;
        issue(6'd2, 1'b0, t0 + 14, 6'd2);
        hi = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            check("s_des_sel", int'(des_sel), 2);
            if (des_reset) hi++;
        end
        check("s_reset_cycles", hi, 8);

        // Reset asserted mid-RESET discards the in-flight switch
        issue(6'd5, 1'b0, cyc + 14, 6'd5);
        repeat (6) @(negedge clock);
        req_valid = 1'b0;
        check("r_in_reset_state", int'(des_reset), 1);
        #1 reset = 1'b0;
        #1;
        check("r_des_sel", int'(des_sel), 0);
        check("r_des_reset", int'(des_reset), 0);
        check("r_out_en", int'(out_en), 0);
        check("r_busy", int'(busy), 0);
        check("r_pulses", int'({done, err}), 0);
        sb.delete();
        @(negedge clock);
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("r_ready", int'(req_ready), 1);
        check("r_des_sel_held", int'(des_sel), 0);

        // Parameter corner S=1, R=1: 5-cycle latency
        c_req_valid = 1'b1;
        c_req_sel   = 6'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            c_req_valid = 1'b0;
            check("c_done", int'(c_done), int'(k == 5));
            check("c_out_en", int'(c_out_en), int'(k == 5));
            check("c_des_reset", int'(c_des_reset), int'(k == 3));
            check("c_des_sel", int'(c_des_sel), (k >= 2) ? 3 : 0);
        end

        repeat (4) @(negedge clock);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
